// File: rtl/avalon_mm_wm_pkg.sv
// Shared types and helpers for the Avalon-MM burst write master.
//   wm_state_t      : FSM encoding (IDLE, WAIT, BURST)
//   clog2()         : ceiling log2 for elaboration-time sizing
//   byte_lane_mask(): low-n-lanes-enabled mask, used for a partial final beat
package avalon_mm_wm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } wm_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Mask with the low nbytes lanes set; nbytes == 0 yields an empty mask.
    function automatic logic [63:0] byte_lane_mask(input int nbytes);
        return (64'd1 << nbytes) - 64'd1;
    endfunction

endpackage

// File: rtl/avalon_mm_wm_fifo.sv
// Show-ahead synchronous FIFO feeding the write master's data bus.
// Ports:
//   clk, reset_n : clock, asynchronous active-low clear (flushes contents)
//   data, push   : write side; a push while full is dropped
//   pop          : read side; a pop while empty is ignored
//   q            : current head word, valid whenever !empty
//   used         : occupancy 0..FIFODEPTH
//   full, empty  : occupancy flags
module avalon_mm_wm_fifo #(
    parameter int DATAWIDTH      = 32,
    parameter int FIFODEPTH      = 64,
    parameter int FIFODEPTH_LOG2 = 6
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [DATAWIDTH-1:0]      data,
    input  logic                      push,
    input  logic                      pop,
    output logic [DATAWIDTH-1:0]      q,
    output logic [FIFODEPTH_LOG2:0]   used,
    output logic                      full,
    output logic                      empty
);

    logic [DATAWIDTH-1:0]      mem [FIFODEPTH];
    logic [FIFODEPTH_LOG2-1:0] wr_ptr;
    logic [FIFODEPTH_LOG2-1:0] rd_ptr;
    logic                      do_push;
    logic                      do_pop;

    assign full    = (used == (FIFODEPTH_LOG2 + 1)'(FIFODEPTH));
    assign empty   = (used == '0);
    // A push while full is lost even if a pop frees a slot in the same cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign q       = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + FIFODEPTH_LOG2'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + FIFODEPTH_LOG2'(1);
            end
            case ({do_push, do_pop})
                2'b10:   used <= used + (FIFODEPTH_LOG2 + 1)'(1);
                2'b01:   used <= used - (FIFODEPTH_LOG2 + 1)'(1);
                default: used <= used;
            endcase
        end
    end

    // Storage is not cleared; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data;
        end
    end

endmodule

// File: rtl/avalon_mm_burst_write_master.sv
// Bursting Avalon-MM write master. User logic pushes words into an internal
// FIFO; after control_go the block writes control_write_length bytes starting
// at control_write_base in bursts of up to MAXBURSTCOUNT beats, then returns
// to idle (control_done=1).
// Ports:
//   clk, reset_n                 : clock, asynchronous active-low reset
//   control_fixed_location       : single-beat bursts, address never advances
//   control_write_base/_length   : byte start address / byte count
//   control_go / control_done    : start pulse (IDLE only) / idle indicator
//   user_write_buffer/_buffer_data/_buffer_full : FIFO push side
//   master_*                     : Avalon-MM burst write master interface
// Build option: define AVMM_WM_PARTIAL_BE_EN to round the length up to whole
// beats and mask the unused lanes of the final beat; otherwise trailing
// remainder bytes are not written and byteenable is always all-ones.
module avalon_mm_burst_write_master
    import avalon_mm_wm_pkg::*;
#(
    parameter int DATAWIDTH       = 32,
    parameter int BYTEENABLEWIDTH = 4,
    parameter int ADDRESSWIDTH    = 32,
    parameter int MAXBURSTCOUNT   = 8,
    parameter int BURSTCOUNTWIDTH = 4,
    parameter int FIFODEPTH       = 64,
    parameter int FIFODEPTH_LOG2  = 6
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       control_fixed_location,
    input  logic [ADDRESSWIDTH-1:0]    control_write_base,
    input  logic [ADDRESSWIDTH-1:0]    control_write_length,
    input  logic                       control_go,
    output logic                       control_done,
    input  logic                       user_write_buffer,
    input  logic [DATAWIDTH-1:0]       user_buffer_data,
    output logic                       user_buffer_full,
    output logic [ADDRESSWIDTH-1:0]    master_address,
    output logic                       master_write,
    output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
    output logic [DATAWIDTH-1:0]       master_writedata,
    output logic [BURSTCOUNTWIDTH-1:0] master_burstcount,
    input  logic                       master_waitrequest
);

    localparam int ADDR_SHIFT = clog2(BYTEENABLEWIDTH);
    localparam logic [ADDRESSWIDTH-1:0] LANE_MASK = ADDRESSWIDTH'(BYTEENABLEWIDTH - 1);

    wm_state_t                  state;
    wm_state_t                  state_next;
    logic [ADDRESSWIDTH-1:0]    addr_q;
    logic [ADDRESSWIDTH-1:0]    words_left;
    logic [ADDRESSWIDTH-1:0]    words_in;
    logic [BURSTCOUNTWIDTH-1:0] beats_left;
    logic [BURSTCOUNTWIDTH-1:0] blen;
    logic                       fixed_q;
    logic [FIFODEPTH_LOG2:0]    fifo_used;
    logic                       fifo_empty;
    logic                       start_xfer;
    logic                       start_burst;
    logic                       beat_accept;
    logic                       last_beat;

`ifdef AVMM_WM_PARTIAL_BE_EN
    logic [ADDRESSWIDTH-1:0]    rem_in;
    logic [ADDRESSWIDTH-1:0]    rem_q;
    assign rem_in   = control_write_length & LANE_MASK;
    assign words_in = (control_write_length >> ADDR_SHIFT) + ADDRESSWIDTH'(rem_in != '0);
`else
    assign words_in = control_write_length >> ADDR_SHIFT;
`endif

    avalon_mm_wm_fifo #(
        .DATAWIDTH     (DATAWIDTH),
        .FIFODEPTH     (FIFODEPTH),
        .FIFODEPTH_LOG2(FIFODEPTH_LOG2)
    ) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .data   (user_buffer_data),
        .push   (user_write_buffer),
        .pop    (beat_accept & ~fifo_empty),
        .q      (master_writedata),
        .used   (fifo_used),
        .full   (user_buffer_full),
        .empty  (fifo_empty)
    );

    // master_write is decoded from state so that reset removes it immediately.
    assign master_write = (state == BURST);
    assign control_done = (state == IDLE);
    assign start_xfer   = (state == IDLE) && control_go && (words_in != '0);
    assign beat_accept  = master_write & ~master_waitrequest;
    assign last_beat    = beat_accept && (beats_left == BURSTCOUNTWIDTH'(1));

    always_comb begin
        blen = BURSTCOUNTWIDTH'(MAXBURSTCOUNT);
        if (fixed_q) begin
            blen = BURSTCOUNTWIDTH'(1);
        end else if (words_left < ADDRESSWIDTH'(MAXBURSTCOUNT)) begin
            blen = words_left[BURSTCOUNTWIDTH-1:0];
        end
    end

    // A burst only starts once all its data is already queued, so it can never
    // run dry part way through.
    assign start_burst = (state == WAIT) && (32'(fifo_used) >= 32'(blen));

`ifdef AVMM_WM_PARTIAL_BE_EN
    always_comb begin
        master_byteenable = '1;
        if ((state == BURST) && (words_left == ADDRESSWIDTH'(1)) && (rem_q != '0)) begin
            master_byteenable = BYTEENABLEWIDTH'(byte_lane_mask(int'(rem_q)));
        end
    end
`else
    assign master_byteenable = '1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_xfer) state_next = WAIT;
            WAIT:    if (start_burst) state_next = BURST;
            BURST:   if (last_beat) state_next = (words_left == ADDRESSWIDTH'(1)) ? IDLE : WAIT;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q            <= '0;
            words_left        <= '0;
            beats_left        <= '0;
            fixed_q           <= 1'b0;
            master_address    <= '0;
            master_burstcount <= '0;
`ifdef AVMM_WM_PARTIAL_BE_EN
            rem_q             <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start_xfer) begin
                        addr_q     <= control_write_base & ~LANE_MASK;
                        words_left <= words_in;
                        fixed_q    <= control_fixed_location;
`ifdef AVMM_WM_PARTIAL_BE_EN
                        rem_q      <= rem_in;
`endif
                    end
                end
                WAIT: begin
                    if (start_burst) begin
                        master_address    <= addr_q;
                        master_burstcount <= blen;
                        beats_left        <= blen;
                    end
                end
                BURST: begin
                    if (beat_accept) begin
                        beats_left <= beats_left - BURSTCOUNTWIDTH'(1);
                        words_left <= words_left - ADDRESSWIDTH'(1);
                        if (last_beat && !fixed_q) begin
                            addr_q <= addr_q + (ADDRESSWIDTH'(master_burstcount) << ADDR_SHIFT);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_mm_burst_write_master.sv
// Directed bench for avalon_mm_burst_write_master: table of transfers plus
// hand-written FIFO-full and mid-burst-reset sequences.
module tb_avalon_mm_burst_write_master;

    logic        clk;
    logic        reset_n;
    logic        control_fixed_location;
    logic [31:0] control_write_base;
    logic [31:0] control_write_length;
    logic        control_go;
    logic        control_done;
    logic        user_write_buffer;
    logic [31:0] user_buffer_data;
    logic        user_buffer_full;
    logic [31:0] master_address;
    logic        master_write;
    logic [3:0]  master_byteenable;
    logic [31:0] master_writedata;
    logic [3:0]  master_burstcount;
    logic        master_waitrequest;

    avalon_mm_burst_write_master dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .control_fixed_location(control_fixed_location),
        .control_write_base    (control_write_base),
        .control_write_length  (control_write_length),
        .control_go            (control_go),
        .control_done          (control_done),
        .user_write_buffer     (user_write_buffer),
        .user_buffer_data      (user_buffer_data),
        .user_buffer_full      (user_buffer_full),
        .master_address        (master_address),
        .master_write          (master_write),
        .master_byteenable     (master_byteenable),
        .master_writedata      (master_writedata),
        .master_burstcount     (master_burstcount),
        .master_waitrequest    (master_waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] base;
        logic [31:0] length;
        logic        fixed;
        logic        rand_wait;
        int          npush;
        int          exp_beats;
        int          exp_bursts;
        logic [31:0] exp_addr0;
        logic [31:0] exp_addr1;
        logic [3:0]  exp_bc0;
        logic [3:0]  exp_bc1;
        logic [3:0]  exp_last_be;
    } vec_t;

    int          tests;
    int          fails;
    int          data_seed;
    bit          rand_wait;
    logic [31:0] exp_q[$];

    // Beat monitor state
    bit          in_burst;
    int          beat_in_burst;
    logic [31:0] cur_addr;
    logic [3:0]  cur_bc;
    logic [31:0] burst_addr[$];
    logic [3:0]  burst_bc[$];
    int          beats;
    logic [3:0]  last_be;
    int          data_err;
    int          stab_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d, input bit kept);
        user_write_buffer = 1'b1;
        user_buffer_data  = d;
        tick();
        user_write_buffer = 1'b0;
        if (kept) exp_q.push_back(d);
    endtask

    task automatic clear_mon();
        burst_addr.delete();
        burst_bc.delete();
        beats    = 0;
        data_err = 0;
        stab_err = 0;
        last_be  = '0;
    endtask

    task automatic start_go(input logic [31:0] base, input logic [31:0] len, input logic fixed);
        control_write_base     = base;
        control_write_length   = len;
        control_fixed_location = fixed;
        control_go             = 1'b1;
        tick();
        control_go             = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!control_done && n < 3000) begin
            tick();
            n++;
        end
        check({name, "_done_timeout"}, control_done, 1'b1);
    endtask

    // Waitrequest driver: changes just after the rising edge.
    initial begin
        master_waitrequest = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            master_waitrequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Samples the bus mid-cycle; a beat is accepted at the next rising edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            in_burst      = 1'b0;
            beat_in_burst = 0;
        end else if (master_write) begin
            if (!in_burst) begin
                in_burst      = 1'b1;
                beat_in_burst = 0;
                cur_addr      = master_address;
                cur_bc        = master_burstcount;
                burst_addr.push_back(master_address);
                burst_bc.push_back(master_burstcount);
            end else if (master_address !== cur_addr || master_burstcount !== cur_bc) begin
                stab_err++;
            end
            if (!master_waitrequest) begin
                beats++;
                last_be = master_byteenable;
                if (exp_q.size() == 0) data_err++;
                else if (master_writedata !== exp_q.pop_front()) data_err++;
                beat_in_burst++;
                if (beat_in_burst >= int'(cur_bc)) in_burst = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int   n;

        tests = 0;
        fails = 0;
        data_seed = 32'h0000_A000;
        rand_wait = 1'b0;
        clear_mon();

        vecs[0] = '{"len64",   32'h0000_1000, 32'd64, 1'b0, 1'b0, 16, 16, 2, 32'h0000_1000, 32'h0000_1020, 4'd8, 4'd8, 4'hF};
        vecs[1] = '{"len40",   32'h0000_2000, 32'd40, 1'b0, 1'b1, 10, 10, 2, 32'h0000_2000, 32'h0000_2020, 4'd8, 4'd2, 4'hF};
        vecs[2] = '{"fixed16", 32'h0000_3000, 32'd16, 1'b1, 1'b1,  4,  4, 4, 32'h0000_3000, 32'h0000_3000, 4'd1, 4'd1, 4'hF};
        vecs[3] = '{"wrap",    32'hFFFF_FFE0, 32'd64, 1'b0, 1'b0, 16, 16, 2, 32'hFFFF_FFE0, 32'h0000_0000, 4'd8, 4'd8, 4'hF};
        vecs[4] = '{"len0",    32'h0000_9000, 32'd0,  1'b0, 1'b0,  0,  0, 0, 32'h0,         32'h0,         4'd0, 4'd0, 4'h0};
`ifdef AVMM_WM_PARTIAL_BE_EN
        vecs[5] = '{"len10",   32'h0000_4003, 32'd10, 1'b0, 1'b1,  3,  3, 1, 32'h0000_4000, 32'h0,         4'd3, 4'd0, 4'b0011};
        vecs[6] = '{"len3",    32'h0000_5000, 32'd3,  1'b0, 1'b0,  1,  1, 1, 32'h0000_5000, 32'h0,         4'd1, 4'd0, 4'b0111};
`else
        vecs[5] = '{"len10",   32'h0000_4003, 32'd10, 1'b0, 1'b1,  2,  2, 1, 32'h0000_4000, 32'h0,         4'd2, 4'd0, 4'b1111};
        vecs[6] = '{"len3",    32'h0000_5000, 32'd3,  1'b0, 1'b0,  0,  0, 0, 32'h0,         32'h0,         4'd0, 4'd0, 4'h0};
`endif

        reset_n                = 1'b0;
        control_fixed_location = 1'b0;
        control_write_base     = '0;
        control_write_length   = '0;
        control_go             = 1'b0;
        user_write_buffer      = 1'b0;
        user_buffer_data       = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done",       control_done,      1'b1);
        check("rst_write",      master_write,      1'b0);
        check("rst_address",    master_address,    32'h0);
        check("rst_burstcount", master_burstcount, 4'h0);
        check("rst_byteenable", master_byteenable, 4'hF);
        check("rst_full",       user_buffer_full,  1'b0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            clear_mon();
            rand_wait = vecs[i].rand_wait;
            for (int k = 0; k < vecs[i].npush; k++) begin
                push_word(32'(data_seed), 1'b1);
                data_seed++;
            end
            start_go(vecs[i].base, vecs[i].length, vecs[i].fixed);
            if (vecs[i].exp_beats == 0) begin
                check({vecs[i].name, "_done_stays"}, control_done, 1'b1);
                repeat (5) tick();
                check({vecs[i].name, "_done_after"}, control_done, 1'b1);
            end else begin
                check({vecs[i].name, "_done_low"}, control_done, 1'b0);
                wait_done(vecs[i].name);
            end
            tick();
            rand_wait = 1'b0;
            check({vecs[i].name, "_beats"},  beats,             vecs[i].exp_beats);
            check({vecs[i].name, "_bursts"}, burst_addr.size(), vecs[i].exp_bursts);
            check({vecs[i].name, "_data"},   data_err,          0);
            check({vecs[i].name, "_stable"}, stab_err,          0);
            if (burst_addr.size() > 0 && vecs[i].exp_bursts > 0) begin
                check({vecs[i].name, "_addr0"}, burst_addr[0], vecs[i].exp_addr0);
                check({vecs[i].name, "_bc0"},   burst_bc[0],   vecs[i].exp_bc0);
            end
            if (burst_addr.size() > 1 && vecs[i].exp_bursts > 1) begin
                check({vecs[i].name, "_addr1"}, burst_addr[1], vecs[i].exp_addr1);
                check({vecs[i].name, "_bc1"},   burst_bc[1],   vecs[i].exp_bc1);
            end
            if (vecs[i].fixed) begin
                for (int b = 0; b < burst_addr.size(); b++) begin
                    check({vecs[i].name, "_fixed_addr"}, burst_addr[b], vecs[i].base);
                end
            end
            if (vecs[i].exp_beats > 0) begin
                check({vecs[i].name, "_last_be"}, last_be, vecs[i].exp_last_be);
            end
        end

        // FIFO fill to capacity; pushes while full are dropped, including one
        // that coincides with the first pop.
        clear_mon();
        for (int k = 0; k < 64; k++) begin
            if (k == 63) check("fifo_not_full_at_63", user_buffer_full, 1'b0);
            push_word(32'h100 + 32'(k), 1'b1);
        end
        check("fifo_full_at_64", user_buffer_full, 1'b1);
        push_word(32'h0000_DEAD, 1'b0);
        check("fifo_full_after_drop", user_buffer_full, 1'b1);
        start_go(32'h0000_6000, 32'd256, 1'b0);
        check("fifo_go_done_low", control_done, 1'b0);
        tick();
        check("fifo_first_write", master_write, 1'b1);
        check("fifo_full_at_pop", user_buffer_full, 1'b1);
        user_write_buffer = 1'b1;
        user_buffer_data  = 32'h0000_BEEF;
        tick();
        user_write_buffer = 1'b0;
        wait_done("fifo");
        tick();
        check("fifo_beats",  beats,             64);
        check("fifo_bursts", burst_addr.size(), 8);
        check("fifo_data",   data_err,          0);
        check("fifo_empty_not_full", user_buffer_full, 1'b0);
        clear_mon();
        push_word(32'h0000_0077, 1'b1);
        start_go(32'h0000_6800, 32'd4, 1'b0);
        wait_done("fifo_after");
        tick();
        check("fifo_after_beats", beats,    1);
        check("fifo_after_data",  data_err, 0);

        // Reset asserted while beat 3 of 8 is on the bus.
        clear_mon();
        for (int k = 0; k < 8; k++) begin
            push_word(32'h0000_C000 + 32'(k), 1'b1);
        end
        start_go(32'h0000_7000, 32'd32, 1'b0);
        n = 0;
        while (beats < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rstmid_reach_beat2", beats, 2);
        @(posedge clk);
        #2;
        check("rstmid_write_before", master_write, 1'b1);
        reset_n = 1'b0;
        #1;
        check("rstmid_write",      master_write,      1'b0);
        check("rstmid_done",       control_done,      1'b1);
        check("rstmid_burstcount", master_burstcount, 4'h0);
        exp_q.delete();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        clear_mon();
        for (int k = 0; k < 4; k++) begin
            push_word(32'h0000_D000 + 32'(k), 1'b1);
        end
        start_go(32'h0000_8000, 32'd16, 1'b0);
        wait_done("rstmid_fresh");
        tick();
        check("rstmid_fresh_beats", beats,             4);
        check("rstmid_fresh_addr",  burst_addr.size() > 0 ? burst_addr[0] : 32'hFFFF_FFFF, 32'h0000_8000);
        check("rstmid_fresh_data",  data_err,          0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
